amp_seq: RTL and testbench
==========================

# amp_seq

Amplifier power/mute sequencer in the amp_if path. Sits directly upstream of the simple reload timer: it issues single-cycle `timer_start` pulses and consumes `timer_timeout` to time the power-up and settle delays. Between delays it drives the amplifier enable, mute and an 8-bit soft gain ramp. Faults force immediate shutdown and are counted.

## Interface
- `RAMP_DIV`, default 64: clk_in cycles per gain step, legal range 1..65535.
- `clk_in`  in  1  system clock; all logic rises on posedge.
- `resetb`  in  1  asynchronous, active-low reset.
- `amp_en`  in  1  amplifier enable request, level.
- `i2s_lock`  in  1  I2S clock valid, level.
- `fault`  in  1  amplifier fault, level.
- `timer_timeout`  in  1  from timer: high when timer idle/expired, low while counting.
- `timer_start`  out  1  to timer: one-cycle start pulse.
- `amp_pwr_en`  out  1  amplifier supply enable.
- `amp_mute_n`  out  1  amplifier mute release, active high.
- `amp_ready`  out  1  high only in RUN.
- `ramp_gain`  out  8  soft-start gain, 0..255.
- `seq_state`  out  3  current state encoding.
- `fault_cnt`  out  8  saturating count of FAULT entries.
- `amp_en`, `i2s_lock` and `fault` are synchronous to `clk_in`; no synchronizers in this block.

## Operation
- States and encodings: OFF=0, PWRUP=1, WAIT_LOCK=2, SETTLE=3, RAMP_UP=4, RUN=5, RAMP_DN=6, FAULT=7.
- Priority of events in every state: fault > amp_en low > i2s_lock low.
- Any state, fault=1: go to FAULT. ramp_gain forced to 0, amp_mute_n=0, amp_pwr_en=0. fault_cnt increments on entry and saturates at 255.
- FAULT: stays until fault=0 and amp_en=0, then goes to OFF.
- OFF: amp_en=1 goes to PWRUP.
- PWRUP: timer wait (see below). amp_en=0 goes to OFF. On expiry go to WAIT_LOCK.
- WAIT_LOCK: i2s_lock=1 goes to SETTLE. amp_en=0 goes to OFF. No timeout.
- SETTLE: timer wait. amp_en=0 goes to OFF. i2s_lock=0 goes to WAIT_LOCK. On expiry go to RAMP_UP.
- RAMP_UP: ramp_gain +1 per tick. amp_en=0 or i2s_lock=0 goes to RAMP_DN, keeping the current gain. Gain reaching 255 goes to RUN.
- RUN: amp_en=0 or i2s_lock=0 goes to RAMP_DN.
- RAMP_DN: ramp_gain -1 per tick. Gain reaching 0 goes to OFF. amp_en/i2s_lock returning high does not abort the ramp-down.
- Timer wait (PWRUP, SETTLE): an armed flag and a skip flag are cleared on state entry.
  - While !armed and timer_timeout=0: the timer is still busy from an aborted run, so hold without pulsing.
  - While !armed and timer_timeout=1: pulse timer_start for 1 cycle, set armed and skip.
  - The next cycle clears skip and ignores timer_timeout.
  - With armed && !skip && timer_timeout=1: the delay is expired.
- Ramp tick: a 16-bit divider counts 0..RAMP_DIV-1 and runs only in RAMP_UP/RAMP_DN. It clears on entry to either state. The tick is the cycle the counter equals RAMP_DIV-1.
- Gain arithmetic is 8-bit. It never wraps: increment stops at 255, decrement stops at 0.
- Output decode (all registered):
  - amp_pwr_en=1 in states 1..6.
  - amp_mute_n=1 in RAMP_UP, RUN and RAMP_DN.
  - amp_ready=1 in RUN.

## Timing
- Reset values (async assert, sync release): seq_state=OFF, all outputs 0, fault_cnt=0, divider=0, armed=skip=0.
- State transitions take effect one cycle after the condition is sampled. Outputs reflect the new state in that same cycle.
- timer_start is high for exactly the cycle after the arm condition is sampled. Never two consecutive cycles.
- Full ramp 0→255 takes 255·RAMP_DIV cycles. RUN is entered the cycle after gain reaches 255.
- Fault response: one cycle from fault high to amp_pwr_en=0, amp_mute_n=0, ramp_gain=0.
- Reset mid-operation: all outputs drop asynchronously. A pending timer run is handled by the busy-hold rule after reset release.

## Test plan
- Power-up: timer model with 10-cycle delay, RAMP_DIV=4, i2s_lock=1, amp_en 0→1 → exactly two timer_start pulses; amp_mute_n rises on RAMP_UP entry; amp_ready=1 after 1020 ramp cycles with ramp_gain=255.
- Shutdown: in RUN, amp_en→0 → RAMP_DN, gain 255→0 in 1020 cycles, then OFF with amp_pwr_en=0 the same cycle gain is 0 plus one.
- Lock loss: i2s_lock→0 in SETTLE → WAIT_LOCK with no RAMP_UP. Lock returns → fresh timer_start and a new full delay.
- Abort/busy timer: amp_en→0 at cycle 3 of PWRUP, then →1 immediately → timer_start withheld until timer_timeout returns high.
- Fault: fault=1 in RAMP_UP at gain 100 → next cycle FAULT, gain 0, fault_cnt=1. Exit only after fault=0 and amp_en=0. 300 faults → fault_cnt=255.
- Reset: resetb low mid-RAMP_DN → all outputs 0 immediately; resumes at OFF.

Source files
------------

// File: rtl/amp_seq.sv
// Amplifier power/mute sequencer: timer-paced power-up/settle, soft gain ramp, fault shutdown.
// Latency: one cycle from a sampled condition to the new state and registered outputs; no backpressure.
module amp_seq #(
    parameter int RAMP_DIV = 64
) (
    input  logic       clk_in,
    input  logic       resetb,
    input  logic       amp_en,
    input  logic       i2s_lock,
    input  logic       fault,
    input  logic       timer_timeout,
    output logic       timer_start,
    output logic       amp_pwr_en,
    output logic       amp_mute_n,
    output logic       amp_ready,
    output logic [7:0] ramp_gain,
    output logic [2:0] seq_state,
    output logic [7:0] fault_cnt
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_PWRUP     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_RAMP_UP   = 3'd4,
        S_RUN       = 3'd5,
        S_RAMP_DN   = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(RAMP_DIV - 1);

    state_t      state;
    state_t      state_nxt;
    logic        armed;
    logic        skip;
    logic [15:0] div_cnt;
    logic        timed;
    logic        ramping;
    logic        tick;
    logic        arm_now;
    logic        expired;

    assign seq_state = state;
    assign timed     = (state == S_PWRUP) || (state == S_SETTLE);
    assign ramping   = (state == S_RAMP_UP) || (state == S_RAMP_DN);
    assign tick      = ramping && (div_cnt == DIV_LAST);
    // A low timeout before arming means the timer is still busy from an aborted run.
    assign arm_now   = timed && !armed && timer_timeout;
    // The start-pulse cycle is skipped: the timer has not yet seen the pulse.
    assign expired   = timed && armed && !skip && timer_timeout;

    always_comb begin
        state_nxt = state;
        if (fault) begin
            state_nxt = S_FAULT;
        end else begin
            case (state)
                S_OFF:       if (amp_en) state_nxt = S_PWRUP;
                S_PWRUP: begin
                    if (!amp_en)      state_nxt = S_OFF;
                    else if (expired) state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (!amp_en)       state_nxt = S_OFF;
                    else if (i2s_lock) state_nxt = S_SETTLE;
                end
                S_SETTLE: begin
                    if (!amp_en)        state_nxt = S_OFF;
                    else if (!i2s_lock) state_nxt = S_WAIT_LOCK;
                    else if (expired)   state_nxt = S_RAMP_UP;
                end
                S_RAMP_UP: begin
                    if (!amp_en || !i2s_lock)   state_nxt = S_RAMP_DN;
                    else if (ramp_gain == 8'hFF) state_nxt = S_RUN;
                end
                S_RUN:       if (!amp_en || !i2s_lock) state_nxt = S_RAMP_DN;
                S_RAMP_DN:   if (ramp_gain == 8'h00) state_nxt = S_OFF;
                S_FAULT:     if (!amp_en) state_nxt = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state       <= S_OFF;
            armed       <= 1'b0;
            skip        <= 1'b0;
            div_cnt     <= 16'd0;
            timer_start <= 1'b0;
            amp_pwr_en  <= 1'b0;
            amp_mute_n  <= 1'b0;
            amp_ready   <= 1'b0;
            ramp_gain   <= 8'd0;
            fault_cnt   <= 8'd0;
        end else begin
            state       <= state_nxt;
            timer_start <= arm_now && (state_nxt == state);

            if (state_nxt != state) begin
                armed <= 1'b0;
                skip  <= 1'b0;
            end else if (arm_now) begin
                armed <= 1'b1;
                skip  <= 1'b1;
            end else begin
                skip  <= 1'b0;
            end

            if ((state_nxt != state) || !ramping || tick) div_cnt <= 16'd0;
            else                                         div_cnt <= div_cnt + 16'd1;

            if (state_nxt == S_FAULT) begin
                ramp_gain <= 8'd0;
            end else if (tick && (state_nxt == state)) begin
                if ((state == S_RAMP_UP) && (ramp_gain != 8'hFF)) ramp_gain <= ramp_gain + 8'd1;
                if ((state == S_RAMP_DN) && (ramp_gain != 8'h00)) ramp_gain <= ramp_gain - 8'd1;
            end

            if ((state_nxt == S_FAULT) && (state != S_FAULT) && (fault_cnt != 8'hFF))
                fault_cnt <= fault_cnt + 8'd1;

            amp_pwr_en <= (state_nxt != S_OFF) && (state_nxt != S_FAULT);
            amp_mute_n <= (state_nxt == S_RAMP_UP) || (state_nxt == S_RUN) || (state_nxt == S_RAMP_DN);
            amp_ready  <= (state_nxt == S_RUN);
        end
    end

endmodule

// File: tb/tb_amp_seq.sv
// Bench for amp_seq: hand-derived vector table, directed multi-cycle sequences, random stimulus vs reference model.
module tb_amp_seq;

    localparam int DIV  = 4;
    localparam int TDLY = 10;

    logic       clk_in = 1'b0;
    logic       resetb = 1'b1;
    logic       amp_en = 1'b0;
    logic       i2s_lock = 1'b0;
    logic       fault = 1'b0;
    logic       timer_timeout = 1'b1;
    logic       timer_start;
    logic       amp_pwr_en;
    logic       amp_mute_n;
    logic       amp_ready;
    logic [7:0] ramp_gain;
    logic [2:0] seq_state;
    logic [7:0] fault_cnt;

    amp_seq #(.RAMP_DIV(DIV)) dut (
        .clk_in(clk_in), .resetb(resetb), .amp_en(amp_en), .i2s_lock(i2s_lock),
        .fault(fault), .timer_timeout(timer_timeout), .timer_start(timer_start),
        .amp_pwr_en(amp_pwr_en), .amp_mute_n(amp_mute_n), .amp_ready(amp_ready),
        .ramp_gain(ramp_gain), .seq_state(seq_state), .fault_cnt(fault_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       en, lk, flt;
        logic [2:0] st;
        logic       ts, pwr;
        logic [7:0] fc;
    } vec_t;
    vec_t tbl [15];

    int n_chk = 0;
    int n_pass = 0;
    int tcnt = 0;
    int n_ts = 0;
    int n4 = 0;
    int n6 = 0;

    // Reference model state: phase number, gain as a function of cycles spent ramping.
    int m_st, m_gain, m_g0, m_k, m_fc, m_age;
    bit m_pulsed, m_ts;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    endtask

    function automatic vec_t row(input logic en, lk, flt, input logic [2:0] st,
                                 input logic ts, pwr, input logic [7:0] fc);
        vec_t r;
        r.en = en; r.lk = lk; r.flt = flt; r.st = st; r.ts = ts; r.pwr = pwr; r.fc = fc;
        return r;
    endfunction

    function automatic logic [31:0] exp_vec();
        logic pwr, mute, rdy;
        pwr  = (m_st >= 1) && (m_st <= 6);
        mute = (m_st >= 4) && (m_st <= 6);
        rdy  = (m_st == 5);
        return {9'd0, 3'(m_st), pwr, mute, rdy, m_ts, 8'(m_gain), 8'(m_fc)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {9'd0, seq_state, amp_pwr_en, amp_mute_n, amp_ready, timer_start, ramp_gain, fault_cnt};
    endfunction

    task automatic model_reset();
        m_st = 0; m_gain = 0; m_g0 = 0; m_k = 0; m_fc = 0; m_age = 0; m_pulsed = 0; m_ts = 0;
    endtask

    task automatic model_step(input logic en, lk, flt, to);
        int nx, g;
        nx = m_st;
        m_ts = 0;
        if (flt) nx = 7;
        else begin
            case (m_st)
                0: if (en) nx = 1;
                1, 3: begin
                    if (!en) nx = 0;
                    else if (m_st == 3 && !lk) nx = 2;
                    else if (!m_pulsed) begin
                        if (to) begin m_ts = 1; m_pulsed = 1; m_age = 0; end
                    end else if (m_age >= 1 && to) nx = (m_st == 1) ? 2 : 4;
                    else m_age++;
                end
                2: if (!en) nx = 0; else if (lk) nx = 3;
                4: begin
                    if (!en || !lk) nx = 6;
                    else if (m_gain == 255) nx = 5;
                    else begin
                        m_k++;
                        g = m_g0 + m_k / DIV;
                        m_gain = (g > 255) ? 255 : g;
                    end
                end
                5: if (!en || !lk) nx = 6;
                6: begin
                    if (m_gain == 0) nx = 0;
                    else begin
                        m_k++;
                        g = m_g0 - m_k / DIV;
                        m_gain = (g < 0) ? 0 : g;
                    end
                end
                default: if (!en) nx = 0;
            endcase
        end
        if (nx != m_st) begin
            m_pulsed = 0; m_age = 0; m_k = 0; m_g0 = m_gain;
            if (nx == 7) begin
                m_gain = 0; m_g0 = 0;
                if (m_fc < 255) m_fc++;
            end
        end
        m_st = nx;
    endtask

    // Reload timer: start sampled on an edge drives timeout low for TDLY cycles.
    task automatic timer_tick(input logic ts_s);
        if (ts_s) begin
            tcnt = TDLY; timer_timeout = 1'b0;
        end else if (tcnt > 0) begin
            tcnt--;
            if (tcnt == 0) timer_timeout = 1'b1;
        end
    endtask

    task automatic step();
        logic ts_s, to_s;
        ts_s = timer_start;
        to_s = timer_timeout;
        @(posedge clk_in);
        #1;
        model_step(amp_en, i2s_lock, fault, to_s);
        timer_tick(ts_s);
        check("cycle", dut_vec(), exp_vec());
        if (timer_start) n_ts++;
        if (seq_state == 3'd4) n4++;
        if (seq_state == 3'd6) n6++;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int i;
        i = 0;
        while (seq_state != 3'(s) && i < budget) begin step(); i++; end
        check(name, 32'(seq_state), 32'(s));
    endtask

    task automatic wait_gain(input int g, input int budget, input string name);
        int i;
        i = 0;
        while (ramp_gain != 8'(g) && i < budget) begin step(); i++; end
        check(name, 32'(ramp_gain), 32'(g));
    endtask

    task automatic hold_reset(input int cycles);
        resetb = 1'b0;
        #1;
        check("reset_async", dut_vec(), 32'd0);
        repeat (cycles) begin @(posedge clk_in); #1; timer_tick(1'b0); end
        resetb = 1'b1;
        model_reset();
    endtask

    initial begin
        int s;
        tbl[0]  = row(0, 0, 0, 3'd0, 0, 0, 8'd0);
        tbl[1]  = row(1, 0, 0, 3'd1, 0, 1, 8'd0);
        tbl[2]  = row(1, 0, 0, 3'd1, 1, 1, 8'd0);
        tbl[3]  = row(1, 0, 0, 3'd1, 0, 1, 8'd0);
        tbl[4]  = row(1, 0, 1, 3'd7, 0, 0, 8'd1);
        tbl[5]  = row(0, 0, 1, 3'd7, 0, 0, 8'd1);
        tbl[6]  = row(1, 0, 0, 3'd7, 0, 0, 8'd1);
        tbl[7]  = row(0, 0, 0, 3'd0, 0, 0, 8'd1);
        tbl[8]  = row(0, 0, 1, 3'd7, 0, 0, 8'd2);
        tbl[9]  = row(0, 0, 0, 3'd0, 0, 0, 8'd2);
        tbl[10] = row(1, 0, 0, 3'd1, 0, 1, 8'd2);
        tbl[11] = row(1, 0, 0, 3'd1, 0, 1, 8'd2);
        tbl[12] = row(1, 0, 0, 3'd1, 0, 1, 8'd2);
        tbl[13] = row(1, 0, 0, 3'd1, 0, 1, 8'd2);
        tbl[14] = row(1, 0, 0, 3'd1, 1, 1, 8'd2);

        #2;
        hold_reset(3);

        for (int i = 0; i < 15; i++) begin
            amp_en = tbl[i].en; i2s_lock = tbl[i].lk; fault = tbl[i].flt;
            step();
            check($sformatf("tbl%0d", i), 32'({seq_state, timer_start, amp_pwr_en, fault_cnt}),
                  32'({tbl[i].st, tbl[i].ts, tbl[i].pwr, tbl[i].fc}));
        end

        // Abort PWRUP right after the pulse, re-request: start must wait for the busy timer.
        amp_en = 1'b0; step();
        check("abort_off", 32'(seq_state), 32'd0);
        amp_en = 1'b1; step();
        s = 0;
        while (!timer_start && s < 40) begin step(); s++; end
        check("busy_hold_len", 32'(s), 32'd10);
        wait_state(2, 40, "pwrup_expire");

        // Full power-up from OFF.
        amp_en = 1'b0; step();
        n_ts = 0; n4 = 0;
        amp_en = 1'b1; i2s_lock = 1'b1;
        wait_state(5, 2000, "reach_run");
        check("pwrup_pulses", 32'(n_ts), 32'd2);
        check("ramp_up_cycles", 32'(n4), 32'd1021);
        check("run_gain", 32'(ramp_gain), 32'd255);
        check("run_ready", 32'(amp_ready), 32'd1);

        // Shutdown ramp.
        n6 = 0;
        amp_en = 1'b0;
        wait_state(0, 2000, "reach_off");
        check("ramp_dn_cycles", 32'(n6), 32'd1021);
        check("off_pwr", 32'(amp_pwr_en), 32'd0);

        // Lock loss in SETTLE, then a fresh delay.
        amp_en = 1'b1;
        wait_state(3, 100, "reach_settle");
        i2s_lock = 1'b0; step();
        check("lock_loss", 32'(seq_state), 32'd2);
        n_ts = 0;
        i2s_lock = 1'b1;
        wait_state(4, 100, "relock_ramp");
        check("relock_pulses", 32'(n_ts), 32'd1);

        // Fault mid-ramp.
        wait_gain(100, 600, "gain100");
        fault = 1'b1; step();
        check("fault_state", 32'(seq_state), 32'd7);
        check("fault_gain", 32'(ramp_gain), 32'd0);
        check("fault_cnt1", 32'(fault_cnt), 32'd3);
        fault = 1'b0; step();
        check("fault_hold_en", 32'(seq_state), 32'd7);
        amp_en = 1'b0; step();
        check("fault_exit", 32'(seq_state), 32'd0);

        for (int i = 0; i < 300; i++) begin
            fault = 1'b1; step();
            fault = 1'b0; step();
        end
        check("fault_sat", 32'(fault_cnt), 32'd255);

        // Reset during ramp-down.
        amp_en = 1'b1; i2s_lock = 1'b1;
        wait_state(4, 100, "ramp2");
        wait_gain(20, 200, "gain20");
        amp_en = 1'b0; step();
        check("ramp_dn_entry", 32'(seq_state), 32'd6);
        repeat (10) step();
        #2;
        hold_reset(2);
        step();
        check("post_reset_off", 32'(seq_state), 32'd0);

        // Random stimulus against the model.
        amp_en = 1'b1; i2s_lock = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 799) == 0) amp_en = ~amp_en;
            if ($urandom_range(0, 999) == 0) i2s_lock = ~i2s_lock;
            fault = ($urandom_range(0, 1499) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
